// File: rtl/block_mem_responder.sv
// block_mem_responder: 128-bit block backing store with a fixed access latency.
// One request is accepted in IDLE, counted down in WAIT, performed on the last
// WAIT edge, and announced by a single-cycle complete pulse in DONE.
module block_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [127:0]      din,
    output logic [127:0]      dout,
    output logic              complete,
    output logic              busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [127:0]      din_q;
    logic [127:0]      mem [0:(1<<ADDR_W)-1];
    logic              access;

    // The access happens on the final WAIT edge; reset forces IDLE, so an
    // abandoned write can never reach the array.
    assign access   = (state == S_WAIT) && (cnt == '0);
    assign busy     = (state != S_IDLE);
    assign complete = (state == S_DONE);

    // Control FSM, request latch, latency counter and read-data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_wr  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            dout   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (we || re) begin
                        op_wr  <= we;   // we wins when both are high
                        addr_q <= addr;
                        din_q  <= din;
                        cnt    <= CNT_LOAD;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!op_wr) dout <= mem[addr_q];
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage array: not reset, contents survive rst_n
    always_ff @(posedge clk) begin
        if (access && op_wr) mem[addr_q] <= din_q;
    end

endmodule

// File: tb/tb_block_mem_responder.sv
// Scoreboard bench: each accepted request pushes its expected dout and the
// cycle its complete pulse must appear; the monitor pops and compares.
module tb_block_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 0, re = 0;
    logic [AW-1:0] addr = '0;
    logic [127:0]  din = '0;
    logic [127:0]  dout;
    logic          complete, busy;

    logic          we1 = 0, re1 = 0;
    logic [AW-1:0] addr1 = '0;
    logic [127:0]  din1 = '0;
    logic [127:0]  dout1;
    logic          complete1, busy1;

    block_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .din(din),
        .dout(dout), .complete(complete), .busy(busy));

    block_mem_responder #(.ADDR_W(AW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we1), .re(re1), .addr(addr1), .din(din1),
        .dout(dout1), .complete(complete1), .busy(busy1));

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [127:0] dout_exp;
        int           cyc_exp;
    } sb_t;

    sb_t          sb[$];
    logic [127:0] mdl [int];
    logic [127:0] mdl_dout = '0;
    logic         prev_cmp = 1'b0;

    // Monitor: compare every completion against the oldest scoreboard entry
    always @(negedge clk) begin
        if (complete) begin
            chk("single_pulse", prev_cmp, 1'b0);
            if (sb.size() == 0) begin
                chk("spurious_complete", 1'b1, 1'b0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("dout", dout, e.dout_exp);
                chk("complete_cycle", cyc, e.cyc_exp);
            end
        end
        prev_cmp <= complete;
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || complete) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 1'b1, 1'b0);
    endtask

    // Issue one request on the LATENCY=4 instance and record its expectation
    task automatic req(input logic w, input logic r, input logic [AW-1:0] a, input logic [127:0] d);
        sb_t e;
        wait_idle();
        we = w; re = r; addr = a; din = d;
        if (w) mdl[int'(a)] = d;
        else   mdl_dout = mdl[int'(a)];
        e.dout_exp = mdl_dout;
        e.cyc_exp  = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        we = 0; re = 0;
        addr = ~a; din = ~d;   // must not disturb the in-flight access
    endtask

    initial begin
        logic [127:0] a5;
        int n0, bcnt, ccyc;
        a5 = {16{8'hA5}};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_complete", complete, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dout", dout, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // write then read back, LATENCY=4
        req(1, 0, 10'd3, a5);
        req(0, 1, 10'd3, '0);

        // we and re together act as a write
        req(1, 1, 10'd7, 128'h1234);
        req(0, 1, 10'd7, '0);

        // reset during a pending write leaves memory untouched
        req(1, 0, 10'd5, 128'hCAFE);
        wait_idle();
        we = 1; addr = 10'd5; din = 128'hFFFF;
        @(negedge clk);
        we = 0;
        @(negedge clk);
        chk("wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_complete", complete, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_dout", dout, '0);
        mdl_dout = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        req(0, 1, 10'd5, '0);

        // top and bottom addresses
        req(1, 0, 10'h3FF, {4{32'hDEADBEEF}});
        req(1, 0, 10'h000, {4{32'h01234567}});
        req(0, 1, 10'h3FF, '0);
        req(0, 1, 10'h000, '0);

        // re held: three reads spaced LATENCY+2 edges apart
        wait_idle();
        n0 = cyc;
        re = 1; addr = 10'd3;
        mdl_dout = a5;
        for (int k = 0; k < 3; k++) begin
            sb_t e;
            e.dout_exp = a5;
            e.cyc_exp  = n0 + 1 + LAT + k * (LAT + 2);
            sb.push_back(e);
        end
        repeat (1 + 2 * (LAT + 2)) @(negedge clk);
        re = 0;

        // LATENCY=1 instance: complete after E1, busy for 2 cycles
        n0 = cyc;
        re1 = 1; addr1 = 10'd0;
        bcnt = 0; ccyc = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            re1 = 0;
            if (busy1) bcnt++;
            if (complete1 && ccyc < 0) ccyc = cyc;
        end
        chk("lat1_complete_cycle", ccyc, n0 + 2);
        chk("lat1_busy_cycles", bcnt, 2);

        // drain scoreboard
        begin
            int n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("sb_drained", sb.size(), 0);
        end
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
